// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce, one-hot key code and new_key strobe.
// Optional auto-repeat while a key is held is built when KEY_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 3,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int REPEAT_CYCLES   = 12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        new_key,
  output logic [15:0] key_pressed_value,
  output logic        key_held
);

  // state    | meaning
  // SCAN     | walk columns, look for exactly one low row
  // PRESS_DB | candidate key must stay stable for DEBOUNCE_CYCLES
  // PRESSED  | key accepted, watching only the candidate row bit
  // REL_DB   | candidate row high, must stay high for DEBOUNCE_CYCLES
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  localparam int MAX_SD = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
`ifdef KEY_REPEAT_EN
  localparam int MAX_P = (REPEAT_CYCLES > MAX_SD) ? REPEAT_CYCLES : MAX_SD;
`else
  localparam int MAX_P = MAX_SD;
`endif
  localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    cols_q, cols_d;
  logic [15:0]   kpv_q, kpv_d;
  logic          new_key_q, new_key_d;
  logic          held_q, held_d;
  logic [3:0]    rs_meta_q, rs_q;

  logic          hit;
  logic [1:0]    hit_row;
  logic [3:0]    cand_pat;

`ifdef KEY_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta_q <= 4'b1111;
      rs_q      <= 4'b1111;
    end else begin
      rs_meta_q <= rows;
      rs_q      <= rs_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      cols_q    <= 4'b1110;
      kpv_q     <= 16'h0000;
      new_key_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cols_q    <= cols_d;
      kpv_q     <= kpv_d;
      new_key_q <= new_key_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    case (rs_q)
      4'b1110: begin hit = 1'b1; hit_row = 2'd0; end
      4'b1101: begin hit = 1'b1; hit_row = 2'd1; end
      4'b1011: begin hit = 1'b1; hit_row = 2'd2; end
      4'b0111: begin hit = 1'b1; hit_row = 2'd3; end
      default: begin hit = 1'b0; hit_row = 2'd0; end
    endcase
  end

  assign cand_pat = ~(4'b0001 << row_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    col_d     = col_q;
    row_d     = row_q;
    kpv_d     = kpv_q;
    new_key_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (hit) begin
            row_d   = hit_row;
            state_d = ST_PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_PRESS_DB: begin
        if (rs_q != cand_pat) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_PRESSED;
          cnt_d     = '0;
          kpv_d     = 16'h0001 << {row_q, col_q};
          new_key_d = 1'b1;
`ifdef KEY_REPEAT_EN
          rpt_d     = '0;
`endif
        end
      end
      ST_PRESSED: begin
        cnt_d = '0;
        if (rs_q[row_q]) begin
          state_d = ST_REL_DB;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rpt_q == RPT_LAST) begin
            new_key_d = 1'b1;
            rpt_d     = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
`endif
        end
      end
      ST_REL_DB: begin
        if (!rs_q[row_q]) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
    // column drive and held flag are registered from next-state so they never glitch
    cols_d = ~(4'b0001 << col_d);
    held_d = (state_d == ST_PRESSED) || (state_d == ST_REL_DB);
  end

  assign cols              = cols_q;
  assign new_key           = new_key_q;
  assign key_pressed_value = kpv_q;
  assign key_held          = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: keypad model drives rows from cols, monitor checks strobes.
module tb_keypad_scanner;
  localparam int SC = 3, DB = 4, RP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows, cols;
  logic        new_key, key_held;
  logic [15:0] kpv;
  logic [15:0] keys_dn;

  int n_tests = 0, n_fail = 0, strobe_cnt = 0, rep_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_key = 16'h0;
  logic        nk_prev = 1'b0;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .new_key(new_key),
    .key_pressed_value(kpv), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // physical keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    rows = 4'hF;
    for (int i = 0; i < 16; i++)
      if (keys_dn[i] && !cols[i % 4]) rows[i / 4] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset) begin
      n_tests++;
      if ($countones(~cols) != 1) begin
        n_fail++;
        $display("FAIL cols_one_low: got %b expected exactly one low bit", cols);
      end
      if (new_key && nk_prev) begin
        n_fail++;
        $display("FAIL strobe_back_to_back: got two consecutive new_key cycles expected one");
      end
      if (new_key) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_key", {16'h0, kpv}, {16'h0, e});
          strobe_cnt++;
          last_key = e;
        end
`ifdef KEY_REPEAT_EN
        else if (key_held) begin
          check("repeat_key", {16'h0, kpv}, {16'h0, last_key});
          rep_cnt++;
        end
`endif
        else begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got new_key with key %h expected no strobe", kpv);
        end
      end
      nk_prev = new_key;
    end else begin
      nk_prev = 1'b0;
    end
  end

  initial begin
    logic [3:0]  exp4;
    logic [15:0] kbit;
    int s0, k, found;

    reset   = 1'b1;
    keys_dn = 16'h0;
    cyc(2);
    check("rst_cols", {28'h0, cols}, 32'he);
    check("rst_new_key", {31'h0, new_key}, 32'h0);
    check("rst_kpv", {16'h0, kpv}, 32'h0);
    check("rst_held", {31'h0, key_held}, 32'h0);
    reset = 1'b0;

    // test 1: reset pulse mid-scan, then column walk with no keys
    cyc(4);
    #1 reset = 1'b1;
    #1 check("async_rst_cols", {28'h0, cols}, 32'he);
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp4 = ~(4'b0001 << ((i / SC) % 4));
      check("scan_cols", {28'h0, cols}, {28'h0, exp4});
      cyc(1);
    end
    cyc(25);
    check("idle_strobes", strobe_cnt, 0);
    check("idle_kpv", {16'h0, kpv}, 32'h0);

    // test 2: r1/c2 held
    s0 = strobe_cnt;
    exp_q.push_back(16'h0040);
    keys_dn = 16'h0040;
    cyc(30);
    check("t2_one_strobe", strobe_cnt, s0 + 1);
    check("t2_kpv", {16'h0, kpv}, 32'h0040);
    check("t2_held", {31'h0, key_held}, 32'h1);
    check("t2_cols", {28'h0, cols}, 32'hb);

    // test 4: release bounce, then real release
    keys_dn = 16'h0;
    cyc(2);
    keys_dn = 16'h0040;
    cyc(10);
    check("t4_bounce_held", {31'h0, key_held}, 32'h1);
    check("t4_bounce_no_strobe", strobe_cnt, s0 + 1);
    keys_dn = 16'h0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!key_held) begin found = 1; break; end
      cyc(1);
    end
    check("t4_release_seen", found, 1);
    check("t4_resume_cols", {28'h0, cols}, 32'h7);
    check("t4_kpv_kept", {16'h0, kpv}, 32'h0040);
    cyc(10);

    // test 3: press bounce on r2/c0
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (cols == 4'b1110) begin found = 1; break; end
      cyc(1);
    end
    check("t3_col0_seen", found, 1);
    s0 = strobe_cnt;
    exp_q.push_back(16'h0100);
    keys_dn = 16'h0100; cyc(2);
    keys_dn = 16'h0;    cyc(1);
    keys_dn = 16'h0100; cyc(5);
    check("t3_no_early_strobe", strobe_cnt, s0);
    cyc(25);
    check("t3_one_strobe", strobe_cnt, s0 + 1);
    check("t3_kpv", {16'h0, kpv}, 32'h0100);
    keys_dn = 16'h0;
    cyc(20);

    // test 5: two keys in column 0
    s0 = strobe_cnt;
    keys_dn = 16'h0011;
    cyc(40);
    check("t5_no_strobe", strobe_cnt, s0);
    check("t5_not_held", {31'h0, key_held}, 32'h0);
    keys_dn = 16'h0;
    cyc(5);

    // reset while debouncing r2/c1
    keys_dn = 16'h0200;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (cols == 4'b1101) begin found = 1; break; end
      cyc(1);
    end
    check("t5_col1_seen", found, 1);
    cyc(4);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_cols", {28'h0, cols}, 32'he);
    check("t5_rst_new_key", {31'h0, new_key}, 32'h0);
    check("t5_rst_kpv", {16'h0, kpv}, 32'h0);
    check("t5_rst_held", {31'h0, key_held}, 32'h0);
    keys_dn = 16'h0;
    cyc(2);
    reset = 1'b0;
    cyc(5);

`ifdef KEY_REPEAT_EN
    // test 6: auto-repeat on r3/c3
    s0 = strobe_cnt;
    exp_q.push_back(16'h8000);
    keys_dn = 16'h8000;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (strobe_cnt != s0) begin found = 1; break; end
      cyc(1);
    end
    check("t6_first_strobe", found, 1);
    s0 = rep_cnt;
    cyc(30);
    check("t6_repeats", rep_cnt - s0, 3);
    check("t6_kpv", {16'h0, kpv}, 32'h8000);
    keys_dn = 16'h0;
    cyc(20);
`endif

    // randomized presses with bounce on both edges
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(0, 15);
      kbit = 16'h0001 << k;
      exp_q.push_back(kbit);
      repeat ($urandom_range(0, 3)) begin
        keys_dn = kbit; cyc($urandom_range(1, 2));
        keys_dn = 16'h0; cyc(1);
      end
      keys_dn = kbit;
      cyc(30 + $urandom_range(0, 20));
      exp4 = ~(4'b0001 << (k % 4));
      check("rand_held", {31'h0, key_held}, 32'h1);
      check("rand_cols", {28'h0, cols}, {28'h0, exp4});
      check("rand_kpv", {16'h0, kpv}, {16'h0, kbit});
      repeat ($urandom_range(0, 3)) begin
        keys_dn = 16'h0; cyc($urandom_range(1, 2));
        keys_dn = kbit;  cyc($urandom_range(1, 3));
      end
      keys_dn = 16'h0;
      cyc(20 + $urandom_range(0, 10));
      check("rand_released", {31'h0, key_held}, 32'h0);
    end

    check("all_strobes_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
